// File: rtl/acq_seq_pkg.sv
// Shared types and defaults for the two-channel acquisition sequencer.
package acq_seq_pkg;

   localparam int TMR_W_DEF = 24;
   localparam int CNT_W_DEF = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HOLDOFF = 3'd1,
      ARMED   = 3'd2,
      CAPTURE = 3'd3,
      READY   = 3'd4
   } seq_state_t;

   typedef enum logic [1:0] {
      STOP   = 2'd0,
      SINGLE = 2'd1,
      NORMAL = 2'd2,
      AUTO   = 2'd3
   } acq_mode_t;

   // Modes that re-arm on their own after a readout or from IDLE.
   function automatic logic mode_rearms(input acq_mode_t m);
      return (m == NORMAL) || (m == AUTO);
   endfunction

endpackage

// File: rtl/acq_timer.sv
// Loadable down-counter that stops at zero; shared by the holdoff delay
// and the auto-trigger timeout.
module acq_timer
   import acq_seq_pkg::*;
#(
   parameter int TMR_W = TMR_W_DEF
) (
   input  logic             clk_50,
   input  logic             reset,
   input  logic             load,
   input  logic [TMR_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [TMR_W-1:0] cnt_q;
   logic [TMR_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_50) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/acq_sequencer.sv
// Arm/trigger/capture/readout sequencer driving both scope channels from
// one common trigger pulse; all outputs are registered.
module acq_sequencer
   import acq_seq_pkg::*;
#(
   parameter int AUTO_TIMEOUT = 5_000_000,
   parameter int TMR_W        = TMR_W_DEF,
   parameter int CNT_W        = CNT_W_DEF
) (
   input  logic             clk_50,
   input  logic             reset,
   input  logic [1:0]       mode,
   input  logic             run_req,
   input  logic             trig_src,
   input  logic             trigger_1,
   input  logic             trigger_2,
   input  logic             cap_done_1,
   input  logic             cap_done_2,
   input  logic             read_ack,
   input  logic [15:0]      holdoff,
   output logic             acq_enable,
   output logic             chan_trigger,
   output logic             data_ready,
   output logic             forced_trig,
   output logic [2:0]       seq_state,
   output logic [CNT_W-1:0] capture_count
);

   localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'(AUTO_TIMEOUT - 1);

   seq_state_t state_q, state_d;
   acq_mode_t  mode_s;

   logic trig_1_q, trig_2_q;
   logic edge_sel;

   logic             tmr_load;
   logic [TMR_W-1:0] tmr_load_val;
   logic             tmr_dec;
   logic             tmr_zero;

   logic fire, fire_forced, cap_complete;

   logic             acq_enable_q,    acq_enable_d;
   logic             chan_trigger_q,  chan_trigger_d;
   logic             data_ready_q,    data_ready_d;
   logic             forced_trig_q,   forced_trig_d;
   logic [CNT_W-1:0] capture_count_q, capture_count_d;

   assign mode_s   = acq_mode_t'(mode);
   // Rising edge only, so a level already high on arming never fires.
   assign edge_sel = trig_src ? (trigger_2 & ~trig_2_q) : (trigger_1 & ~trig_1_q);

   acq_timer #(
      .TMR_W (TMR_W)
   ) u_timer (
      .clk_50   (clk_50),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .dec      (tmr_dec),
      .zero     (tmr_zero)
   );

   always_ff @(posedge clk_50) begin
      if (reset) begin
         state_q  <= IDLE;
         trig_1_q <= 1'b0;
         trig_2_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         trig_1_q <= trigger_1;
         trig_2_q <= trigger_2;
      end
   end

   always_comb begin
      state_d      = state_q;
      tmr_load     = 1'b0;
      tmr_load_val = TMR_W'(holdoff);
      tmr_dec      = 1'b0;
      fire         = 1'b0;
      fire_forced  = 1'b0;
      cap_complete = 1'b0;
      case (state_q)
         IDLE: begin
            if (((mode_s == SINGLE) && run_req) || mode_rearms(mode_s)) begin
               state_d  = HOLDOFF;
               tmr_load = 1'b1;
            end
         end
         HOLDOFF: begin
            if (mode_s == STOP) begin
               state_d = IDLE;
            end else if (tmr_zero) begin
               state_d      = ARMED;
               tmr_load     = 1'b1;
               tmr_load_val = TMO_LOAD;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         ARMED: begin
            // STOP beats a real edge, which beats the auto timeout.
            if (mode_s == STOP) begin
               state_d = IDLE;
            end else if (edge_sel) begin
               state_d = CAPTURE;
               fire    = 1'b1;
            end else if ((mode_s == AUTO) && tmr_zero) begin
               state_d     = CAPTURE;
               fire        = 1'b1;
               fire_forced = 1'b1;
            end else begin
               tmr_dec = (mode_s == AUTO);
            end
         end
         CAPTURE: begin
            if (cap_done_1 && cap_done_2) begin
               state_d      = READY;
               cap_complete = 1'b1;
            end
         end
         READY: begin
            if (read_ack) begin
               if (mode_rearms(mode_s)) begin
                  state_d  = HOLDOFF;
                  tmr_load = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      acq_enable_d    = (state_d == ARMED) || (state_d == CAPTURE);
      chan_trigger_d  = fire;
      data_ready_d    = (state_d == READY);
      forced_trig_d   = fire ? fire_forced : forced_trig_q;
      capture_count_d = capture_count_q + CNT_W'(cap_complete);
   end

   always_ff @(posedge clk_50) begin
      if (reset) begin
         acq_enable_q    <= 1'b0;
         chan_trigger_q  <= 1'b0;
         data_ready_q    <= 1'b0;
         forced_trig_q   <= 1'b0;
         capture_count_q <= '0;
      end else begin
         acq_enable_q    <= acq_enable_d;
         chan_trigger_q  <= chan_trigger_d;
         data_ready_q    <= data_ready_d;
         forced_trig_q   <= forced_trig_d;
         capture_count_q <= capture_count_d;
      end
   end

   assign acq_enable    = acq_enable_q;
   assign chan_trigger  = chan_trigger_q;
   assign data_ready    = data_ready_q;
   assign forced_trig   = forced_trig_q;
   assign seq_state     = state_q;
   assign capture_count = capture_count_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer: a cycle table for a NORMAL acquisition
// plus hand-written sequences for the auto, single and reset corner cases.
module tb_acq_sequencer;

   localparam int TMO = 8;

   logic        clk_50 = 1'b0;
   logic        reset, run_req, trig_src, trigger_1, trigger_2;
   logic        cap_done_1, cap_done_2, read_ack;
   logic [1:0]  mode;
   logic [15:0] holdoff;
   logic        acq_enable, chan_trigger, data_ready, forced_trig;
   logic [2:0]  seq_state;
   logic [15:0] capture_count;

   always #10 clk_50 = ~clk_50;

   acq_sequencer #(
      .AUTO_TIMEOUT (TMO),
      .TMR_W        (24),
      .CNT_W        (16)
   ) dut (
      .clk_50        (clk_50),
      .reset         (reset),
      .mode          (mode),
      .run_req       (run_req),
      .trig_src      (trig_src),
      .trigger_1     (trigger_1),
      .trigger_2     (trigger_2),
      .cap_done_1    (cap_done_1),
      .cap_done_2    (cap_done_2),
      .read_ack      (read_ack),
      .holdoff       (holdoff),
      .acq_enable    (acq_enable),
      .chan_trigger  (chan_trigger),
      .data_ready    (data_ready),
      .forced_trig   (forced_trig),
      .seq_state     (seq_state),
      .capture_count (capture_count)
   );

   typedef struct {
      logic       rst;
      logic [1:0] md;
      logic       rr, ts, t1, t2, c1, c2, ra;
      logic [2:0] st;
      logic       ae, ct, dr, ft;
      logic [15:0] cnt;
   } vec_t;

   vec_t tbl[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic vec_t mk(input logic rst, input logic [1:0] md, input logic rr,
                               input logic ts, input logic t1, input logic t2,
                               input logic c1, input logic c2, input logic ra,
                               input logic [2:0] st, input logic ae, input logic ct,
                               input logic dr, input logic ft, input logic [15:0] cnt);
      vec_t v;
      v.rst = rst; v.md = md; v.rr = rr; v.ts = ts; v.t1 = t1; v.t2 = t2;
      v.c1 = c1; v.c2 = c2; v.ra = ra;
      v.st = st; v.ae = ae; v.ct = ct; v.dr = dr; v.ft = ft; v.cnt = cnt;
      return v;
   endfunction

   function automatic logic [22:0] outs();
      return {seq_state, acq_enable, chan_trigger, data_ready, forced_trig, capture_count};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_50);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; mode = 2'd0; run_req = 1'b0; trig_src = 1'b0;
      trigger_1 = 1'b0; trigger_2 = 1'b0; cap_done_1 = 1'b0; cap_done_2 = 1'b0;
      read_ack = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   task automatic wait_state(input logic [2:0] st, input int max, input string name);
      int n = 0;
      while (seq_state !== st && n < max) begin
         tick();
         n++;
      end
      check(name, 32'(seq_state), 32'(st));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected $finish");
      $fatal(1);
   end

   initial begin
      int n;
      holdoff = 16'd3;
      do_reset();

      // rst md rr ts t1 t2 c1 c2 ra | st ae ct dr ft cnt
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 2, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 2, 0, 0, 0, 1, 0, 0, 0, 2, 1, 0, 0, 0, 0));
      for (int i = 0; i < 8; i++)
         tbl.push_back(mk(0, 2, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 2, 0, 0, 1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 2, 0, 0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 2, 0, 0, 1, 0, 1, 1, 0, 4, 0, 0, 1, 0, 1));
      tbl.push_back(mk(0, 2, 0, 0, 1, 0, 1, 1, 0, 4, 0, 0, 1, 0, 1));
      tbl.push_back(mk(0, 2, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

      foreach (tbl[i]) begin
         reset = tbl[i].rst; mode = tbl[i].md; run_req = tbl[i].rr; trig_src = tbl[i].ts;
         trigger_1 = tbl[i].t1; trigger_2 = tbl[i].t2;
         cap_done_1 = tbl[i].c1; cap_done_2 = tbl[i].c2; read_ack = tbl[i].ra;
         tick();
         check($sformatf("vec%0d", i), 32'(outs()),
               32'({tbl[i].st, tbl[i].ae, tbl[i].ct, tbl[i].dr, tbl[i].ft, tbl[i].cnt}));
         $display("vec %0d: state=%0d en=%0b trig=%0b rdy=%0b forced=%0b count=%0d",
                  i, seq_state, acq_enable, chan_trigger, data_ready, forced_trig, capture_count);
      end

      // Auto timeout: forced trigger exactly TMO cycles after arming.
      holdoff = 16'd0;
      do_reset();
      mode = 2'd3;
      wait_state(3'd2, 10, "autoA_armed");
      n = 0;
      while (chan_trigger !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("autoA_latency", n, TMO);
      check("autoA_state", 32'(seq_state), 3);
      tick();
      check("autoA_pulse_len", 32'(chan_trigger), 0);
      cap_done_1 = 1'b1; cap_done_2 = 1'b1;
      tick();
      check("autoA_ready", 32'({seq_state, data_ready, forced_trig}), {3'd4, 1'b1, 1'b1});
      cap_done_1 = 1'b0; cap_done_2 = 1'b0; read_ack = 1'b1;
      tick();
      read_ack = 1'b0;
      check("autoA_rearm", 32'({seq_state, data_ready}), {3'd1, 1'b0});
      $display("seq autoA done: latency=%0d", n);

      // Real edge on trigger_2 coinciding with the timeout wins.
      trig_src = 1'b1;
      wait_state(3'd2, 10, "autoB_armed");
      for (int i = 0; i < TMO - 1; i++) begin
         trigger_1 = (i == 3);
         tick();
         check("autoB_wait", 32'(chan_trigger), 0);
      end
      trigger_1 = 1'b0;
      trigger_2 = 1'b1;
      tick();
      check("autoB_fire", 32'({seq_state, chan_trigger, forced_trig}), {3'd3, 1'b1, 1'b0});
      tick();
      check("autoB_one_pulse", 32'(chan_trigger), 0);
      cap_done_1 = 1'b1; cap_done_2 = 1'b1;
      tick();
      check("autoB_ready", 32'({data_ready, forced_trig, capture_count}), {1'b1, 1'b0, 16'd2});
      $display("seq autoB done");

      // SINGLE: runs once on run_req, then stays idle.
      do_reset();
      mode = 2'd1;
      repeat (3) tick();
      check("single_idle", 32'(seq_state), 0);
      run_req = 1'b1;
      tick();
      run_req = 1'b0;
      check("single_holdoff", 32'(seq_state), 1);
      tick();
      check("single_armed", 32'(seq_state), 2);
      trigger_1 = 1'b1;
      tick();
      check("single_capture", 32'(seq_state), 3);
      trigger_1 = 1'b0; cap_done_1 = 1'b1; cap_done_2 = 1'b1;
      tick();
      check("single_ready", 32'({seq_state, capture_count}), {3'd4, 16'd1});
      cap_done_1 = 1'b0; cap_done_2 = 1'b0; read_ack = 1'b1;
      tick();
      read_ack = 1'b0;
      check("single_back_idle", 32'({seq_state, data_ready}), {3'd0, 1'b0});
      repeat (5) tick();
      check("single_no_rearm", 32'({seq_state, acq_enable}), {3'd0, 1'b0});
      $display("seq single done");

      // Staggered capture done, STOP mid-capture does not abort.
      do_reset();
      mode = 2'd2;
      wait_state(3'd2, 10, "cap_armed");
      trigger_1 = 1'b1;
      tick();
      trigger_1 = 1'b0;
      check("cap_enter", 32'(seq_state), 3);
      for (int t = 0; t < 10; t++) begin
         cap_done_1 = (t >= 5);
         cap_done_2 = (t == 9);
         mode = (t >= 7) ? 2'd0 : 2'd2;
         tick();
         if (t < 9) check($sformatf("cap_t%0d", t + 1), 32'(seq_state), 3);
         else check("cap_ready_t10", 32'({seq_state, data_ready}), {3'd4, 1'b1});
      end
      cap_done_1 = 1'b0; cap_done_2 = 1'b0; read_ack = 1'b1;
      tick();
      read_ack = 1'b0;
      check("cap_stop_idle", 32'(seq_state), 0);
      $display("seq capture done");

      // Level high across arming does not trigger; then reset in READY.
      do_reset();
      trigger_1 = 1'b1;
      mode = 2'd2;
      wait_state(3'd2, 10, "lvl_armed");
      repeat (4) begin
         tick();
         check("lvl_no_trig", 32'({seq_state, chan_trigger}), {3'd2, 1'b0});
      end
      trigger_1 = 1'b0;
      tick();
      check("lvl_fall", 32'(chan_trigger), 0);
      trigger_1 = 1'b1;
      tick();
      check("lvl_rise", 32'({seq_state, chan_trigger}), {3'd3, 1'b1});
      cap_done_1 = 1'b1; cap_done_2 = 1'b1;
      tick();
      check("lvl_ready", 32'({seq_state, data_ready}), {3'd4, 1'b1});
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("reset_in_ready", 32'(outs()), 0);
      $display("seq level/reset done");

      // STOP takes priority over a same-cycle edge in ARMED.
      trigger_1 = 1'b0; cap_done_1 = 1'b0; cap_done_2 = 1'b0;
      wait_state(3'd2, 10, "stop_armed");
      mode = 2'd0;
      trigger_1 = 1'b1;
      tick();
      check("stop_priority", 32'({seq_state, chan_trigger, acq_enable}), {3'd0, 1'b0, 1'b0});
      $display("seq stop priority done");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
